// File: rtl/fifo_stream_pkg.sv
// Shared helpers for the FIFO family: counter and pointer widths, wrapping pointer increment.
package fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Wraps explicitly at depth-1 so non power-of-two depths never alias.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_stream_if.sv
// Valid/ready streaming bundle: write side (in_*) and FWFT read side (out_*).
interface fifo_stream_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fifo_stream_ram.sv
// FIFO storage: one clocked write port, one asynchronous read port, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_stream.sv
// Synchronous FWFT stream FIFO with occupancy, almost flags, high-water mark and flush.
module fifo_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2,
  parameter int CNT_WIDTH = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  fifo_stream_if.slave         s,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [CNT_WIDTH-1:0] peak_o
);

  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0]        wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d, peak_q, peak_d;
  logic                 full, empty, push, pop;

  assign full  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty = (count_q == '0);

  // Handshakes come from registered state only; flush merely forces them low.
  assign s.in_ready  = !full && !flush_i;
  assign s.out_valid = !empty && !flush_i;
  assign push        = s.in_valid && s.in_ready && !rst;
  assign pop         = s.out_valid && s.out_ready && !rst;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = PW'(ptr_inc(int'(wrPtr_q), DEPTH));
    end
    if (pop) begin
      rdPtr_d = PW'(ptr_inc(int'(rdPtr_q), DEPTH));
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    peak_d = (count_d > peak_q) ? count_d : peak_q;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      peak_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      peak_q  <= peak_d;
    end
  end

  fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (PW)
  ) uRam (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wrPtr_q),
    .wdata_i(s.in_data),
    .raddr_i(rdPtr_q),
    .rdata_o(s.out_data)
  );

  assign count_o        = count_q;
  assign peak_o         = peak_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty_o = (int'(count_q) <= AE_LEVEL);

  // A stalled producer must hold its word until it is taken.
  assert property (@(posedge clk) disable iff (rst || flush_i)
    (s.in_valid && !s.in_ready) |=> $stable(s.in_data));
  assert property (@(posedge clk) disable iff (rst) count_q <= CNT_WIDTH'(DEPTH));
  assert property (@(posedge clk) disable iff (rst) !(push && full) && !(pop && empty));

endmodule

// File: tb/tb_fifo_stream.sv
// Directed bench for fifo_stream (DEPTH=16 and DEPTH=5) against a queue-based reference model.
module tb_fifo_stream;

  logic        clk = 1'b0;
  logic        rstIn = 1'b1;
  logic        flushIn = 1'b0;
  logic        vIn = 1'b0;
  logic [31:0] dIn = '0;
  logic        rOut = 1'b0;
  bit          sel = 1'b0;

  int errCount = 0;
  int checkCount = 0;

  int          mCount, mPeak, md;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  fifo_stream_if #(.WIDTH(32)) bus16 ();
  fifo_stream_if #(.WIDTH(32)) bus5 ();

  logic       flush16, flush5;
  logic [4:0] count16, peak16;
  logic [2:0] count5, peak5;
  logic       full16, empty16, af16, ae16;
  logic       full5, empty5, af5, ae5;

  assign bus16.in_valid  = (sel == 1'b0) ? vIn : 1'b0;
  assign bus16.in_data   = (sel == 1'b0) ? dIn : '0;
  assign bus16.out_ready = (sel == 1'b0) ? rOut : 1'b0;
  assign flush16         = (sel == 1'b0) ? flushIn : 1'b0;
  assign bus5.in_valid   = (sel == 1'b1) ? vIn : 1'b0;
  assign bus5.in_data    = (sel == 1'b1) ? dIn : '0;
  assign bus5.out_ready  = (sel == 1'b1) ? rOut : 1'b0;
  assign flush5          = (sel == 1'b1) ? flushIn : 1'b0;

  fifo_stream #(.WIDTH(32), .DEPTH(16)) dut16 (
    .clk(clk), .rst(rstIn), .flush_i(flush16), .s(bus16.slave),
    .count_o(count16), .full_o(full16), .empty_o(empty16),
    .almost_full_o(af16), .almost_empty_o(ae16), .peak_o(peak16)
  );

  fifo_stream #(.WIDTH(32), .DEPTH(5)) dut5 (
    .clk(clk), .rst(rstIn), .flush_i(flush5), .s(bus5.slave),
    .count_o(count5), .full_o(full5), .empty_o(empty5),
    .almost_full_o(af5), .almost_empty_o(ae5), .peak_o(peak5)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares the pre-edge DUT state against the model, including the FWFT head word.
  task automatic checkOutput();
    logic        inRdy, outVld, fl, em, af, ae;
    logic [31:0] dat, cnt, pk;
    logic        expOutVld;
    if (sel == 1'b0) begin
      inRdy = bus16.in_ready; outVld = bus16.out_valid; dat = bus16.out_data;
      cnt = 32'(count16); pk = 32'(peak16); fl = full16; em = empty16; af = af16; ae = ae16;
    end else begin
      inRdy = bus5.in_ready; outVld = bus5.out_valid; dat = bus5.out_data;
      cnt = 32'(count5); pk = 32'(peak5); fl = full5; em = empty5; af = af5; ae = ae5;
    end
    expOutVld = (mCount != 0) && !flushIn;
    checkValue("in_ready", 32'(inRdy), 32'((mCount != md) && !flushIn));
    checkValue("out_valid", 32'(outVld), 32'(expOutVld));
    checkValue("count", cnt, 32'(mCount));
    checkValue("peak", pk, 32'(mPeak));
    checkValue("full", 32'(fl), 32'(mCount == md));
    checkValue("empty", 32'(em), 32'(mCount == 0));
    checkValue("almost_full", 32'(af), 32'(mCount >= md - 2));
    checkValue("almost_empty", 32'(ae), 32'(mCount <= 2));
    if (expOutVld && q.size() > 0) begin
      checkValue("out_data", dat, q[0]);
    end
  endtask

  // One clock of stimulus: drive at negedge, check, then advance the model as the posedge will.
  task automatic applyStimulus(input bit v, input logic [31:0] d, input bit r,
                               input bit fl, input bit rs, input bit chk);
    bit mPush, mPop;
    @(negedge clk);
    vIn = v; dIn = d; rOut = r; flushIn = fl; rstIn = rs;
    #1;
    if (chk) checkOutput();
    if (rs || fl) begin
      mCount = 0; mPeak = 0; q.delete();
    end else begin
      mPush = v && (mCount < md);
      mPop  = r && (mCount > 0);
      if (mPop) void'(q.pop_front());
      if (mPush) q.push_back(d);
      mCount = mCount + int'(mPush) - int'(mPop);
      if (mCount > mPeak) mPeak = mCount;
    end
  endtask

  initial begin
    md = 16; mCount = 0; mPeak = 0;
    $display("[TB] reset, DEPTH=16");
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);

    $display("[TB] fill 16 words with out_ready low");
    for (int i = 0; i < 16; i++) applyStimulus(1, 32'(i), 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] full with push and pop requested together");
    applyStimulus(1, 32'h77, 1, 0, 0, 1);
    applyStimulus(1, 32'h77, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] drain");
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] single push 0xA5 to empty FIFO");
    applyStimulus(1, 32'hA5, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] mid-stream flush at count 7");
    for (int i = 0; i < 7; i++) applyStimulus(1, 32'h20 + 32'(i), 0, 0, 0, 1);
    applyStimulus(1, 32'h99, 1, 1, 0, 1);
    applyStimulus(1, 32'h11, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] rst and flush together while pushing");
    applyStimulus(1, 32'h55, 0, 0, 0, 1);
    applyStimulus(1, 32'h56, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] DEPTH=5 wrap with continuous push+pop");
    sel = 1'b1; md = 5;
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h40 + 32'(i), 0, 0, 0, 1);
    for (int i = 0; i < 23; i++) applyStimulus(1, 32'h50 + 32'(i), 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
